// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//  Shared RV32I definitions for the issue controller: the nine supported
//  base opcodes, the issue FSM state type and small decode helpers that
//  pick register fields out of a raw instruction word.
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // EMPTY: nothing held; HOLD: held and issuable; BUBBLE: held but stalled
  // behind a load-use dependency.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2
  } issue_state_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL) ||
           (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

  // True when inst reads the register the previously issued load writes.
  function automatic logic load_use_hazard(input logic [31:0] inst,
                                           input logic        last_load,
                                           input logic [4:0]  last_rd);
    return last_load &&
           ((uses_rs1(inst[6:0]) && (inst[19:15] == last_rd)) ||
            (uses_rs2(inst[6:0]) && (inst[24:20] == last_rd)));
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//  Up-counter that sticks at all-ones instead of wrapping, so a long run
//  never reports a misleadingly small count.
//  Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears the count
//   inc    in   add one this cycle (ignored once saturated)
//   count  out  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule

// File: rtl/decode_issue_ctrl.sv
// ---------------------------------------------------------------------------
// decode_issue_ctrl
//  One-entry issue buffer between fetch and the decode/execute stage.
//  Holds a fetched instruction, offers it to execute under valid/ready,
//  stalls one cycle on a load-use dependency and drops wrong-path work on a
//  flush. Saturating counters track issues, bubbles and flushes.
//  Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   if_valid/if_inst/if_pc, if_ready   fetch side handshake
//   id_valid/id_inst/id_pc, id_ready   execute side handshake
//   id_illegal          held opcode is not a supported RV32I opcode
//   flush               taken branch/jump in execute, kill younger work
//   issue_cnt/bubble_cnt/flush_cnt    performance counters
// ---------------------------------------------------------------------------
module decode_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_ready,
  output logic             id_valid,
  output logic [31:0]      id_inst,
  output logic [XLEN-1:0]  id_pc,
  input  logic             id_ready,
  output logic             id_illegal,
  input  logic             flush,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  issue_state_t    r_state;
  issue_state_t    w_next_state;
  logic [31:0]     r_id_inst;
  logic [XLEN-1:0] r_id_pc;
  logic            r_last_load;
  logic [4:0]      r_last_rd;

  logic            w_hold_valid;
  logic            w_hazard;
  logic            w_issue;
  logic            w_accept;
  logic            w_bubble;
  logic            w_next_hold_valid;
  logic [31:0]     w_next_inst;
  logic            w_next_last_load;
  logic [4:0]      w_next_last_rd;

  // The state register alone records occupancy and stall status.
  assign w_hold_valid = (r_state != EMPTY);
  assign w_hazard     = (r_state == BUBBLE);

  assign id_valid   = w_hold_valid & ~w_hazard & ~flush;
  assign w_issue    = id_valid & id_ready;
  assign if_ready   = ~w_hold_valid | w_issue | flush;
  // During a flush the fetched word is handshaken but thrown away.
  assign w_accept   = if_valid & if_ready & ~flush;
  assign w_bubble   = w_hold_valid & w_hazard & ~flush;
  assign id_inst    = r_id_inst;
  assign id_pc      = r_id_pc;
  assign id_illegal = w_hold_valid & ~is_legal(r_id_inst[6:0]);

  // Next-state: work out what will be held and what the last-issued record
  // will say, then classify the next cycle as empty, issuable or stalled.
  // The last-load flag clears whenever nothing issues, so a stall never
  // lasts more than one cycle.
  always_comb begin
    w_next_hold_valid = w_hold_valid;
    w_next_inst       = r_id_inst;
    w_next_last_load  = 1'b0;
    w_next_last_rd    = r_last_rd;
    w_next_state      = EMPTY;

    if (w_issue) begin
      w_next_last_load = (r_id_inst[6:0] == OP_LOAD) && (r_id_inst[11:7] != 5'd0);
      w_next_last_rd   = r_id_inst[11:7];
    end

    if (flush) begin
      w_next_hold_valid = 1'b0;
    end else if (w_accept) begin
      w_next_hold_valid = 1'b1;
      w_next_inst       = if_inst;
    end else if (w_issue) begin
      w_next_hold_valid = 1'b0;
    end

    if (w_next_hold_valid) begin
      if (load_use_hazard(w_next_inst, w_next_last_load, w_next_last_rd)) begin
        w_next_state = BUBBLE;
      end else begin
        w_next_state = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The held instruction only changes on an accept, which cannot happen
  // while an unissued instruction is still waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_inst   <= '0;
      r_id_pc     <= '0;
      r_last_load <= 1'b0;
      r_last_rd   <= 5'd0;
    end else begin
      r_last_load <= w_next_last_load;
      r_last_rd   <= w_next_last_rd;
      if (w_accept) begin
        r_id_inst <= if_inst;
        r_id_pc   <= if_pc;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_issue_cnt (
    .clk(clk), .rst_n(rst_n), .inc(w_issue), .count(issue_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst_n(rst_n), .inc(w_bubble), .count(bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush), .count(flush_cnt)
  );

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decode_issue_ctrl
//  Directed bench for decode_issue_ctrl. The main process drives fetch and
//  execute handshakes and queues every instruction expected to issue; a
//  monitor pops and compares on each real issue. Counters are narrowed to
//  4 bits so saturation is reached by ordinary issuing.
// ---------------------------------------------------------------------------
module tb_decode_issue_ctrl;
  import riscv_pkg::*;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             if_valid;
  logic [31:0]      if_inst;
  logic [XLEN-1:0]  if_pc;
  logic             if_ready;
  logic             id_valid;
  logic [31:0]      id_inst;
  logic [XLEN-1:0]  id_pc;
  logic             id_ready;
  logic             id_illegal;
  logic             flush;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;

  exp_t expQ[$];
  int   compared = 0;
  int   mismatched = 0;
  int   expIssue = 0;
  int   expBubble = 0;
  int   expFlush = 0;

  decode_issue_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready),
    .id_illegal(id_illegal), .flush(flush),
    .issue_cnt(issue_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [31:0] inst,
                               input logic [31:0] pc, input logic rdy,
                               input logic fl);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
    id_ready = rdy;
    flush    = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] inst, input logic [31:0] pc,
                         input logic illegal);
    exp_t e;
    e.inst = inst;
    e.pc = pc;
    e.illegal = illegal;
    expQ.push_back(e);
    if (expIssue < CNT_MAX) expIssue++;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_issue_cnt"}, 32'(issue_cnt), 32'(expIssue));
    checkOutput({tag, "_bubble_cnt"}, 32'(bubble_cnt), 32'(expBubble));
    checkOutput({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(expFlush));
  endtask

  // Monitor: every real issue must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && id_valid && id_ready) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_issue: got 0x%08h expected none at %0t", id_inst, $time);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("issue_inst", id_inst, e.inst);
        checkOutput("issue_pc", id_pc, e.pc);
        checkOutput("issue_illegal", 32'(id_illegal), 32'(e.illegal));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
    checkOutput("rst_if_ready", 32'(if_ready), 32'd1);
    checkCounters("rst");
    tick();
    tick();
    rst_n = 1'b1;

    // Back-to-back add then nop with execute always ready.
    applyStimulus(1'b1, 32'h003100B3, 32'h100, 1'b1, 1'b0);
    pushExp(32'h003100B3, 32'h100, 1'b0);
    checkOutput("t2_empty_id_valid", 32'(id_valid), 32'd0);
    tick();
    applyStimulus(1'b1, 32'h00000013, 32'h104, 1'b1, 1'b0);
    pushExp(32'h00000013, 32'h104, 1'b0);
    checkOutput("t2_add_id_valid", 32'(id_valid), 32'd1);
    checkOutput("t2_if_ready", 32'(if_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t2_nop_id_valid", 32'(id_valid), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkCounters("t2");

    // lw x5 followed by a dependent add: one bubble cycle.
    applyStimulus(1'b1, 32'h0000A283, 32'h200, 1'b1, 1'b0);
    pushExp(32'h0000A283, 32'h200, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00728333, 32'h204, 1'b1, 1'b0);
    pushExp(32'h00728333, 32'h204, 1'b0);
    checkOutput("t3_lw_id_valid", 32'(id_valid), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t3_bubble_id_valid", 32'(id_valid), 32'd0);
    checkOutput("t3_bubble_if_ready", 32'(if_ready), 32'd0);
    expBubble++;
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t3_add_id_valid", 32'(id_valid), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkCounters("t3");

    // lw x0 followed by an add reading x0: no bubble.
    applyStimulus(1'b1, 32'h0000A003, 32'h210, 1'b1, 1'b0);
    pushExp(32'h0000A003, 32'h210, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00700333, 32'h214, 1'b1, 1'b0);
    pushExp(32'h00700333, 32'h214, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t3_x0_no_bubble", 32'(id_valid), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkCounters("t3x0");

    // Reset asserted in the middle of a bubble; the stalled add is lost.
    applyStimulus(1'b1, 32'h0000A283, 32'h220, 1'b1, 1'b0);
    pushExp(32'h0000A283, 32'h220, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00728333, 32'h224, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t1_pre_bubble", 32'(id_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    expIssue = 0;
    expBubble = 0;
    expFlush = 0;
    checkOutput("t1_async_id_valid", 32'(id_valid), 32'd0);
    checkOutput("t1_async_if_ready", 32'(if_ready), 32'd1);
    checkOutput("t1_async_state", 32'(dut.r_state), 32'(EMPTY));
    checkCounters("t1");
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t1_post_id_valid", 32'(id_valid), 32'd0);

    // Backpressure: execute stalls three cycles while fetch keeps offering.
    applyStimulus(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0);
    pushExp(32'h00100093, 32'h300, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h00200113, 32'h304, 1'b0, 1'b0);
      checkOutput("t4_if_ready", 32'(if_ready), 32'd0);
      checkOutput("t4_id_inst", id_inst, 32'h00100093);
      checkOutput("t4_id_pc", id_pc, 32'h300);
      tick();
    end
    applyStimulus(1'b1, 32'h00200113, 32'h304, 1'b1, 1'b0);
    pushExp(32'h00200113, 32'h304, 1'b0);
    checkOutput("t4_release_if_ready", 32'(if_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t4_second_inst", id_inst, 32'h00200113);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkCounters("t4");

    // Flush with one held and one arriving instruction: both dropped.
    applyStimulus(1'b1, 32'h00300193, 32'h400, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00400213, 32'h404, 1'b1, 1'b1);
    expFlush++;
    checkOutput("t5_flush_id_valid", 32'(id_valid), 32'd0);
    checkOutput("t5_flush_if_ready", 32'(if_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 32'h00500293, 32'h408, 1'b1, 1'b0);
    pushExp(32'h00500293, 32'h408, 1'b0);
    checkOutput("t5_dropped_id_valid", 32'(id_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t5_next_id_valid", 32'(id_valid), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkCounters("t5");

    // Stream enough instructions to saturate issue_cnt, then an illegal one.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'h00100093, 32'h500 + 32'(i * 4), 1'b1, 1'b0);
      pushExp(32'h00100093, 32'h500 + 32'(i * 4), 1'b0);
      tick();
    end
    applyStimulus(1'b1, 32'h0000007F, 32'h600, 1'b1, 1'b0);
    pushExp(32'h0000007F, 32'h600, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t6_illegal", 32'(id_illegal), 32'd1);
    checkOutput("t6_illegal_id_valid", 32'(id_valid), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t6_issue_sat", 32'(issue_cnt), 32'(CNT_MAX));
    checkCounters("t6");
    tick();
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
